mux_vector_player: RTL

- Hardware stimulus/check stage that sits directly upstream and downstream of the 2:1 mux.
- Stores up to NVEC 4-bit test vectors {a, b, sel, y_exp} and drives a/b/sel into the mux one vector at a time.
- Samples the mux output y after a programmable settle time and counts mismatches.
- Replaces file-based vector checking for on-board (FPGA) self-test.

---
 rtl/mux_vec_pkg.sv | 22 ++
 rtl/mux_vector_player_vec_mem.sv | 27 ++
 rtl/mux_vector_player.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mux_vec_pkg.sv
// Shared types for the mux vector player:
// FSM states and the packed test-vector layout.
package mux_vec_pkg;

   localparam int VEC_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      WAIT,
      CHECK,
      DONE
   } vp_state_t;

   typedef struct packed {
      logic a;
      logic b;
      logic sel;
      logic y_exp;
   } mux_vec_t;

endpackage

// File: rtl/mux_vector_player_vec_mem.sv
// Vector store: NVEC x VEC_W register file,
// synchronous write, asynchronous read.
module vec_mem
   import mux_vec_pkg::*;
#(
   parameter int NVEC = 8,
   localparam int AW = $clog2(NVEC)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  mux_vec_t      wdata,
   input  logic [AW-1:0] raddr,
   output mux_vec_t      rdata
);

   mux_vec_t mem_q [NVEC];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/mux_vector_player.sv
// Drives stored vectors into a 2:1 mux, samples y after
// a settle delay and scores mismatches.
module mux_vector_player
   import mux_vec_pkg::*;
#(
   parameter int NVEC = 8,
   parameter int SETTLE = 2,
   localparam int AW = $clog2(NVEC)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vec_we,
   input  logic [AW-1:0] vec_addr,
   input  logic [3:0]    vec_wdata,
   input  logic          start,
   input  logic          y,
   output logic          a,
   output logic          b,
   output logic          sel,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW:0]   err_count,
   output logic [AW:0]   vec_count,
   output logic [AW-1:0] first_err
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LD = CW'(SETTLE - 1);

   vp_state_t     state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          y_exp_q, y_exp_d;
   logic [2:0]    abs_q, abs_d;
   logic [AW:0]   err_q, err_d;
   logic [AW:0]   vcnt_q, vcnt_d;
   logic [AW-1:0] ferr_q, ferr_d;
   logic          mem_we;
   mux_vec_t      rvec;

   // Memory is writable only while no run is in flight
   assign mem_we = vec_we &
                   ((state_q == IDLE) || (state_q == DONE));

   vec_mem #(.NVEC(NVEC)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (vec_addr),
      .wdata (mux_vec_t'(vec_wdata)),
      .raddr (idx_q),
      .rdata (rvec)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      y_exp_d = y_exp_q;
      abs_d   = abs_q;
      err_d   = err_q;
      vcnt_d  = vcnt_q;
      ferr_d  = ferr_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = APPLY;
               idx_d   = '0;
               err_d   = '0;
               vcnt_d  = '0;
            end
         end
         APPLY: begin
            abs_d   = {rvec.a, rvec.b, rvec.sel};
            y_exp_d = rvec.y_exp;
            cnt_d   = CNT_LD;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) state_d = CHECK;
            else cnt_d = cnt_q - 1'b1;
         end
         CHECK: begin
            // Case inequality so X/Z on y is a mismatch
            if (y !== y_exp_q) begin
               err_d = err_q + 1'b1;
               if (err_q == '0) ferr_d = idx_q;
            end
            vcnt_d = vcnt_q + 1'b1;
            if (idx_q == AW'(NVEC - 1)) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = APPLY;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         y_exp_q <= 1'b0;
         abs_q   <= '0;
         err_q   <= '0;
         vcnt_q  <= '0;
         ferr_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         y_exp_q <= y_exp_d;
         abs_q   <= abs_d;
         err_q   <= err_d;
         vcnt_q  <= vcnt_d;
         ferr_q  <= ferr_d;
      end
   end

   assign a         = abs_q[2];
   assign b         = abs_q[1];
   assign sel       = abs_q[0];
   assign busy      = (state_q == APPLY) ||
                      (state_q == WAIT) ||
                      (state_q == CHECK);
   assign done      = (state_q == DONE);
   assign pass      = done && (err_q == '0);
   assign err_count = err_q;
   assign vec_count = vcnt_q;
   assign first_err = ferr_q;

endmodule
